// File: rtl/imem_loader_pkg.sv
// Shared definitions for the imem boot loader: FSM state encoding and
// default frame/size constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int         DEF_MAX_WORDS = 4096;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, imem write port and processor control outputs of the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] imem_address;
    logic [31:0]           imem_data;
    logic                  imem_wren;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;

    modport master (
        input  rx_valid, rx_byte,
        output rx_ready, imem_address, imem_data, imem_wren, cpu_reset, done, error
    );

    modport slave (
        output rx_valid, rx_byte,
        input  rx_ready, imem_address, imem_data, imem_wren, cpu_reset, done, error
    );
endinterface

// File: rtl/imem_word_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words and keeps a running XOR of
// every byte since the last clear.
module imem_word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic [7:0]  o_xor
);
    logic [23:0] r_shift;
    logic [1:0]  r_count;
    logic [7:0]  r_xor;

    // The 4th byte completes the word combinationally; the caller registers it.
    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_en && (r_count == 2'd3);
    assign o_xor        = r_xor;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= 2'd0;
            r_xor   <= 8'd0;
        end else if (i_en) begin
            r_count <= r_count + 2'd1;
            r_xor   <= r_xor ^ i_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (i_en) begin
            r_shift <= {r_shift[15:0], i_byte};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time imem loader: parses a framed byte stream, writes words from address 0
// and holds the processor in reset until a checksum-verified image is in place.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 12,
    parameter int         MAX_WORDS  = DEF_MAX_WORDS,
    parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE
) (
    input logic           clock,
    input logic           reset,
    imem_loader_if.master bus
);
    state_t                r_state;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_len;
    logic [ADDR_WIDTH:0]   r_word_idx;
    logic                  r_rx_ready;
    logic                  r_wren;
    logic                  r_cpu_reset;
    logic                  r_done;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [31:0]           r_data;

    logic        w_xfer;
    logic        w_sync;
    logic        w_data_en;
    logic        w_word_valid;
    logic        w_last;
    logic        w_len_bad;
    logic [15:0] w_len;
    logic [31:0] w_word;
    logic [7:0]  w_xor;

    assign w_xfer    = bus.rx_valid && r_rx_ready;
    assign w_sync    = w_xfer && (r_state == IDLE || r_state == ERROR) && (bus.rx_byte == SYNC_BYTE);
    assign w_data_en = w_xfer && (r_state == DATA);
    assign w_len     = {r_len_hi, bus.rx_byte};
    assign w_len_bad = (w_len == 16'd0) || (int'(w_len) > MAX_WORDS);
    // Index is one bit wider than the address so a full-size image never wraps.
    assign w_last    = (16'(r_word_idx) == r_len - 16'd1);

    imem_word_assembler u_asm (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_sync),
        .i_en         (w_data_en),
        .i_byte       (bus.rx_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_xor        (w_xor)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_word_idx  <= '0;
            r_rx_ready  <= 1'b0;
            r_wren      <= 1'b0;
            r_address   <= '0;
            r_data      <= 32'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_rx_ready <= 1'b1;
            r_wren     <= w_word_valid;
            if (w_word_valid) begin
                r_address <= r_word_idx[ADDR_WIDTH-1:0];
                r_data    <= w_word;
            end
            case (r_state)
                IDLE, ERROR: begin
                    if (w_sync) begin
                        r_state    <= LEN_HI;
                        r_word_idx <= '0;
                        r_error    <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= bus.rx_byte;
                        r_state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if (w_len_bad) begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_word_valid) begin
                        r_word_idx <= r_word_idx + 1'b1;
                        if (w_last) begin
                            r_state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (w_xfer) begin
                        if (bus.rx_byte == w_xor) begin
                            r_state     <= DONE;
                            r_cpu_reset <= 1'b0;
                            r_done      <= 1'b1;
                            r_rx_ready  <= 1'b0;
                        end else begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_rx_ready <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready     = r_rx_ready;
    assign bus.imem_address = r_address;
    assign bus.imem_data    = r_data;
    assign bus.imem_wren    = r_wren;
    assign bus.cpu_reset    = r_cpu_reset;
    assign bus.done         = r_done;
    assign bus.error        = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader with a frame-to-image reference model.
module tb_imem_loader;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    imem_loader_if #(.ADDR_WIDTH(12)) bus ();

    imem_loader #(
        .ADDR_WIDTH (12),
        .MAX_WORDS  (4096),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] words[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write strobe seen on the imem port, sampled away from the active edge.
    always @(negedge clock) begin
        if (bus.imem_wren === 1'b1) begin
            wr_addr_q.push_back(bus.imem_address);
            wr_data_q.push_back(bus.imem_data);
        end
    end

    function automatic logic [7:0] xor_of_words();
        logic [7:0] x;
        x = 8'h00;
        foreach (words[i]) x ^= words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
        return x;
    endfunction

    task automatic put_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int guard;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        guard = 0;
        while (bus.rx_ready !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (bus.rx_ready !== 1'b1) begin
            check_val("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
            bus.rx_valid = 1'b0;
            return;
        end
        @(negedge clock);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] nfield, input logic [7:0] chk, input int max_gap);
        wr_addr_q.delete();
        wr_data_q.delete();
        put_byte(8'hA5, max_gap);
        put_byte(nfield[15:8], max_gap);
        put_byte(nfield[7:0], max_gap);
        if (nfield == 16'd0 || nfield > 16'd4096) return;
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                put_byte(words[i][8*b +: 8], max_gap);
                if (b == 0) check_val("wren_latency", 32'(bus.imem_wren), 32'd1);
            end
        end
        check_val("done_before_chk", 32'(bus.done), 32'd0);
        put_byte(chk, max_gap);
    endtask

    // Expected image and status follow directly from the frame contents.
    task automatic check_outcome(input string tag, input logic [15:0] nfield, input logic [7:0] chk);
        bit len_ok;
        bit good;
        int exp_n;
        int n;
        len_ok = (nfield != 16'd0) && (nfield <= 16'd4096);
        good   = len_ok && (chk == xor_of_words());
        exp_n  = len_ok ? words.size() : 0;
        check_val({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(exp_n));
        n = (wr_addr_q.size() < exp_n) ? wr_addr_q.size() : exp_n;
        for (int i = 0; i < n; i++) begin
            check_val({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i % 4096));
            check_val({tag, "_data"}, wr_data_q[i], words[i]);
        end
        check_val({tag, "_done"}, 32'(bus.done), 32'(good));
        check_val({tag, "_error"}, 32'(bus.error), 32'(!good));
        check_val({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(!good));
        check_val({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'(!good));
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check_val({tag, "_wren"}, 32'(bus.imem_wren), 32'd0);
        check_val({tag, "_addr"}, 32'(bus.imem_address), 32'd0);
        check_val({tag, "_data"}, bus.imem_data, 32'd0);
        check_val({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
        check_val({tag, "_done"}, 32'(bus.done), 32'd0);
        check_val({tag, "_error"}, 32'(bus.error), 32'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] chk;
        int         n;

        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        @(negedge clock);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clock);
        check_val("por_ready_after", 32'(bus.rx_ready), 32'd1);

        // Single word frame.
        words = '{32'hDEADBEEF};
        send_frame(16'd1, 8'h22, 0);
        check_outcome("one_word", 16'd1, 8'h22);
        repeat (3) @(negedge clock);
        check_val("done_hold", 32'(bus.done), 32'd1);

        // Zero length, then a good frame clears the error.
        do_reset();
        words.delete();
        send_frame(16'd0, 8'h00, 0);
        check_outcome("len_zero", 16'd0, 8'h00);
        words = '{32'hCAFEF00D, 32'h01234567};
        chk = xor_of_words();
        send_frame(16'd2, chk, 0);
        check_outcome("after_err", 16'd2, chk);

        // Bad checksum, then junk and a gapped good frame from ERROR.
        do_reset();
        words = '{32'h11223344, 32'h55667788};
        send_frame(16'd2, 8'h01, 0);
        check_outcome("bad_chk", 16'd2, 8'h01);
        put_byte(8'h00, 2);
        put_byte(8'hFF, 2);
        chk = xor_of_words();
        send_frame(16'd2, chk, 5);
        check_outcome("gapped", 16'd2, chk);

        // Reset in the middle of the second word.
        do_reset();
        words = '{32'hA1B2C3D4, 32'h0F1E2D3C, 32'h99887766};
        wr_addr_q.delete();
        wr_data_q.delete();
        put_byte(8'hA5, 0);
        put_byte(8'h00, 0);
        put_byte(8'h03, 0);
        for (int b = 3; b >= 0; b--) put_byte(words[0][8*b +: 8], 0);
        put_byte(words[1][31:24], 0);
        put_byte(words[1][23:16], 0);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("mid_reset");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_val("mid_reset_nwr", 32'(wr_addr_q.size()), 32'd1);
        check_val("mid_reset_ready", 32'(bus.rx_ready), 32'd1);
        chk = xor_of_words();
        send_frame(16'd3, chk, 0);
        check_outcome("retransmit", 16'd3, chk);

        // Oversized length.
        do_reset();
        words.delete();
        send_frame(16'd4097, 8'h00, 0);
        check_outcome("too_long", 16'd4097, 8'h00);

        // Random frames.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            words.delete();
            n = int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++) words.push_back($urandom());
            chk = xor_of_words() ^ (($urandom_range(1, 0) == 1) ? 8'h5A : 8'h00);
            if (t > 0) begin
                put_byte(8'($urandom_range(8'hA4, 0)), 1);
            end
            send_frame(16'(n), chk, 3);
            check_outcome("random", 16'(n), chk);
        end

        // Full-size image, data equal to address.
        do_reset();
        words.delete();
        for (int i = 0; i < 4096; i++) words.push_back(32'(i));
        chk = xor_of_words();
        send_frame(16'd4096, chk, 0);
        check_outcome("full", 16'd4096, chk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
